// File: rtl/slew_pkg.sv
// Shared types and elaboration-time helpers for the multichannel slew limiter.
//   state_e   : controller state (IDLE waiting for a strobe, RUN walking channels)
//   calc_step : converts a slew rate in V/s into an LSB step per sample
package slew_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Step in LSBs per sample for a given rate. Full scale (VCC) maps to
    // 2^(WIDTH-2) here, so the result is rate * 2^(WIDTH-2) / vcc / fs.
    // Clamped to at least one LSB so a very slow rate still converges.
    function automatic longint calc_step(input longint rate, input int width,
                                         input longint vcc, input longint fs);
        longint s;
        s = (rate <<< (width - 2)) / vcc / fs;
        if (s < 64'sd1) begin
            s = 64'sd1;
        end
        return s;
    endfunction

endpackage

// File: rtl/slew_step.sv
// One-channel combinational slew datapath, shared by all channels.
//   cur_i    : current registered output of the channel
//   target_i : captured input sample of the channel
//   en_i     : limiting enable (0 = pass target straight through)
//   next_o   : value to load into the channel output register
module slew_step #(
    parameter int WIDTH     = 16,
    parameter int RISE_STEP = 1,
    parameter int FALL_STEP = 1
) (
    input  logic signed [WIDTH-1:0] cur_i,
    input  logic signed [WIDTH-1:0] target_i,
    input  logic                    en_i,
    output logic signed [WIDTH-1:0] next_o
);

    localparam logic signed [WIDTH:0] RS    = (WIDTH+1)'(RISE_STEP);
    localparam logic signed [WIDTH:0] FS    = (WIDTH+1)'(FALL_STEP);
    localparam logic signed [WIDTH:0] FSN   = -FS;
    localparam logic signed [WIDTH:0] MAXV  = (WIDTH+1)'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [WIDTH:0] MINV  = (WIDTH+1)'(-(1 <<< (WIDTH - 1)));

    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] sum;

    // Sign-extend both operands by one bit so the difference never wraps.
    assign diff = (WIDTH+1)'(target_i) - (WIDTH+1)'(cur_i);

    always_comb begin
        sum    = (WIDTH+1)'(target_i);
        next_o = target_i;
        if (en_i) begin
            if (diff > RS) begin
                sum = (WIDTH+1)'(cur_i) + RS;
            end else if (diff < FSN) begin
                sum = (WIDTH+1)'(cur_i) - FS;
            end
            if (sum > MAXV) begin
                next_o = MAXV[WIDTH-1:0];
            end else if (sum < MINV) begin
                next_o = MINV[WIDTH-1:0];
            end else begin
                next_o = sum[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/multichannel_slew_limiter.sv
// Time-multiplexed slew-rate limiter for CHANNELS signed audio channels.
// A strobe in IDLE snapshots all inputs and enables, then one channel per
// clock is pushed through a single shared slew_step datapath.
//   clk          : clock
//   I_RST        : synchronous active-high reset (aborts a frame in flight)
//   audio_clk_en : one-cycle sample strobe
//   in           : packed signed inputs, channel k at [k*WIDTH +: WIDTH]
//   limit_en     : per-channel limiting enable (0 = bypass)
//   out          : registered packed signed outputs
//   out_valid    : one-cycle pulse after the last channel is written
//   busy         : high while a frame is being walked
//   overrun      : sticky, set by a strobe arriving while busy
//
// state | meaning
// IDLE  | waiting for audio_clk_en; outputs held
// RUN   | writing channel idx_q this cycle
module multichannel_slew_limiter
    import slew_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 4,
    parameter int VCC         = 12,
    parameter int SAMPLE_RATE = 48000,
    parameter int RISE_RATE   = 950,
    parameter int FALL_RATE   = 950
) (
    input  logic                      clk,
    input  logic                      I_RST,
    input  logic                      audio_clk_en,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [CHANNELS-1:0]       limit_en,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam longint RISE_STEP = calc_step(longint'(RISE_RATE), WIDTH,
                                             longint'(VCC), longint'(SAMPLE_RATE));
    localparam longint FALL_STEP = calc_step(longint'(FALL_RATE), WIDTH,
                                             longint'(VCC), longint'(SAMPLE_RATE));
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  snap_in_q;
    logic [CHANNELS-1:0]             snap_en_q;
    logic [CHANNELS-1:0][WIDTH-1:0]  out_q;
    logic                            out_valid_q;
    logic                            overrun_q;

    logic                            capture;
    logic                            write;
    logic signed [WIDTH-1:0]         step_out;

    slew_step #(
        .WIDTH     (WIDTH),
        .RISE_STEP (int'(RISE_STEP)),
        .FALL_STEP (int'(FALL_STEP))
    ) u_step (
        .cur_i    (out_q[idx_q]),
        .target_i (snap_in_q[idx_q]),
        .en_i     (snap_en_q[idx_q]),
        .next_o   (step_out)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        write   = 1'b0;
        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                write = 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            snap_in_q   <= '0;
            snap_en_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                snap_in_q <= in;
                snap_en_q <= limit_en;
            end
            if (write) begin
                out_q[idx_q] <= step_out;
            end
            out_valid_q <= write && (idx_q == LAST);
            // A strobe in any RUN cycle, including the final write, is dropped.
            if (audio_clk_en && (state_q == RUN)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == RUN);
    assign overrun   = overrun_q;

endmodule
